// File: rtl/lcd_mem_pkg.sv
// Shared definitions for the LCD multi-bank register memory.
// Holds the per-bank op encodings and the scan engine state type.
package lcd_mem_pkg;

  localparam logic [1:0] OP_READ  = 2'b11;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_IDLE  = 2'b00;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_FETCH,
    SCAN_PRESENT,
    SCAN_DONE
  } scan_state_e;

endpackage

// File: rtl/lcd_mem_bank.sv
// One memory bank: word array, NRD registered read ports, a multi-cycle clear
// engine with busy flag, and an unregistered tap for the top-level scan engine.
module lcd_mem_bank
  import lcd_mem_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 5,
  parameter int NRD = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op,
  input  logic [DW-1:0]     din,
  input  logic [AW-1:0]     waddr,
  input  logic [AW*NRD-1:0] raddr,
  output logic [DW*NRD-1:0] rdata,
  output logic              busy,
  input  logic [AW-1:0]     scan_raddr,
  output logic [DW-1:0]     scan_rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]          mem_q [DEPTH];
  logic [NRD-1:0][DW-1:0] rdata_q;
  logic                   busy_q;
  logic [AW-1:0]          clr_cnt_q;
  logic [AW-1:0]          clr_cnt_d;

  assign clr_cnt_d = clr_cnt_q + 1'b1;

  // While clearing, the bank ignores its op and zeroes one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int r = 0; r < NRD; r++) rdata_q[r] <= '0;
      busy_q    <= 1'b0;
      clr_cnt_q <= '0;
    end else if (busy_q) begin
      mem_q[clr_cnt_q] <= '0;
      clr_cnt_q        <= clr_cnt_d;
      if (clr_cnt_q == '1) busy_q <= 1'b0;
    end else begin
      case (op)
        OP_READ: begin
          for (int r = 0; r < NRD; r++) rdata_q[r] <= mem_q[raddr[r*AW +: AW]];
        end
        OP_WRITE: mem_q[waddr] <= din;
        OP_CLEAR: begin
          busy_q    <= 1'b1;
          clr_cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rdata      = rdata_q;
  assign busy       = busy_q;
  // Read-first: the scan engine samples this tap before any same-edge write.
  assign scan_rdata = mem_q[scan_raddr];

endmodule

// File: rtl/lcd_multibank_mem.sv
// Top of the LCD multi-bank memory: NBANK banks plus a display scan engine that
// streams words of one bank to the LCD driver over a valid/ready handshake.
module lcd_multibank_mem
  import lcd_mem_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int NBANK = 3,
  parameter int NRD   = 3,
  localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           din,
  input  logic [2*NBANK-1:0]      op,
  input  logic [AW*NBANK-1:0]     waddr,
  input  logic [AW*NRD*NBANK-1:0] raddr,
  output logic [DW*NRD*NBANK-1:0] rdata,
  output logic [NBANK-1:0]        bank_busy,
  input  logic                    scan_start,
  input  logic [BW-1:0]           scan_bank,
  input  logic [AW:0]             scan_len,
  output logic                    scan_busy,
  output logic                    scan_valid,
  input  logic                    scan_ready,
  output logic [DW-1:0]           scan_data,
  output logic [AW-1:0]           scan_addr,
  output logic                    scan_done
);

  scan_state_e   state_q;
  logic [BW-1:0] bank_q;
  logic [AW:0]   len_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          done_q;

  logic [DW-1:0] tap [NBANK];
  logic [DW-1:0] scan_word;
  logic          start_empty;
  logic          last_beat;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    lcd_mem_bank #(
      .DW (DW),
      .AW (AW),
      .NRD(NRD)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .op        (op[2*b +: 2]),
      .din       (din),
      .waddr     (waddr[b*AW +: AW]),
      .raddr     (raddr[b*NRD*AW +: NRD*AW]),
      .rdata     (rdata[b*NRD*DW +: NRD*DW]),
      .busy      (bank_busy[b]),
      .scan_raddr(addr_q),
      .scan_rdata(tap[b])
    );
  end

  always_comb begin
    scan_word = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (bank_q == BW'(b)) scan_word = tap[b];
    end
  end

  // An out-of-range bank behaves exactly like a zero-length scan.
  assign start_empty = (scan_len == '0) || (int'(scan_bank) >= NBANK);
  assign last_beat   = ({1'b0, addr_q} == (len_q - 1'b1));
  assign addr_d      = addr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN_IDLE;
      bank_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        SCAN_IDLE: begin
          if (scan_start) begin
            bank_q <= scan_bank;
            len_q  <= scan_len;
            addr_q <= '0;
            if (start_empty) begin
              state_q <= SCAN_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SCAN_FETCH;
            end
          end
        end
        SCAN_FETCH: begin
          data_q  <= scan_word;
          valid_q <= 1'b1;
          state_q <= SCAN_PRESENT;
        end
        SCAN_PRESENT: begin
          if (scan_ready) begin
            valid_q <= 1'b0;
            if (last_beat) begin
              state_q <= SCAN_DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= addr_d;
              state_q <= SCAN_FETCH;
            end
          end
        end
        SCAN_DONE: begin
          done_q  <= 1'b0;
          state_q <= SCAN_IDLE;
        end
        default: state_q <= SCAN_IDLE;
      endcase
    end
  end

  assign scan_busy  = (state_q != SCAN_IDLE);
  assign scan_valid = valid_q;
  assign scan_data  = data_q;
  assign scan_addr  = addr_q;
  assign scan_done  = done_q;

endmodule

// File: tb/tb_lcd_multibank_mem.sv
// Directed self-checking bench for lcd_multibank_mem with hand-computed
// expectations for bank reads/writes, clear, and the scan engine.
module tb_lcd_multibank_mem;
  import lcd_mem_pkg::*;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int NBANK = 3;
  localparam int NRD = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [DW-1:0]           din;
  logic [2*NBANK-1:0]      op;
  logic [AW*NBANK-1:0]     waddr;
  logic [AW*NRD*NBANK-1:0] raddr;
  logic [DW*NRD*NBANK-1:0] rdata;
  logic [NBANK-1:0]        bank_busy;
  logic                    scan_start;
  logic [1:0]              scan_bank;
  logic [AW:0]             scan_len;
  logic                    scan_busy;
  logic                    scan_valid;
  logic                    scan_ready;
  logic [DW-1:0]           scan_data;
  logic [AW-1:0]           scan_addr;
  logic                    scan_done;

  int assertCount = 0;
  int failCount = 0;

  int expData [32];
  int beatAddr [40];
  int beatData [40];
  int beatCycle [40];
  int beatCount, doneCycle, doneSeen, holdErrs, stallSeen, busyErrs, validSeen;

  lcd_multibank_mem #(.DW(DW), .AW(AW), .NBANK(NBANK), .NRD(NRD)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .op        (op),
    .waddr     (waddr),
    .raddr     (raddr),
    .rdata     (rdata),
    .bank_busy (bank_busy),
    .scan_start(scan_start),
    .scan_bank (scan_bank),
    .scan_len  (scan_len),
    .scan_busy (scan_busy),
    .scan_valid(scan_valid),
    .scan_ready(scan_ready),
    .scan_data (scan_data),
    .scan_addr (scan_addr),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change only at the falling edge; outputs are sampled there too.
  task automatic stepClock(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic setOp(input int b, input logic [1:0] code);
    op[2*b +: 2] = code;
  endtask

  task automatic setRead(input int b, input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    raddr[(b*NRD+0)*AW +: AW] = a0;
    raddr[(b*NRD+1)*AW +: AW] = a1;
    raddr[(b*NRD+2)*AW +: AW] = a2;
  endtask

  function automatic logic [7:0] rd(input int b, input int r);
    return rdata[(b*NRD+r)*DW +: DW];
  endfunction

  task automatic applyStimulus(input int b, input logic [1:0] code, input logic [4:0] wa, input logic [7:0] d);
    setOp(b, code);
    waddr[b*AW +: AW] = wa;
    din = d;
    stepClock(1);
    setOp(b, OP_IDLE);
  endtask

  task automatic readBank(input int b, input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    setRead(b, a0, a1, a2);
    applyStimulus(b, OP_READ, 5'd0, 8'd0);
  endtask

  // Starts a scan and records every accepted beat; optionally stalls one beat.
  task automatic runScan(input logic [1:0] bankSel, input logic [5:0] len, input int stallBeat, input int stallCycles);
    int cyc;
    beatCount = 0; doneSeen = 0; doneCycle = -1; holdErrs = 0;
    stallSeen = 0; busyErrs = 0; validSeen = 0;
    scan_bank = bankSel;
    scan_len = len;
    scan_ready = 1'b1;
    scan_start = 1'b1;
    stepClock(1);
    scan_start = 1'b0;
    cyc = 1;
    while (doneSeen == 0 && cyc < 200) begin
      if (!scan_busy) busyErrs++;
      if (scan_done) begin
        doneSeen = 1;
        doneCycle = cyc;
      end else begin
        if (scan_valid) begin
          validSeen++;
          if (beatCount == stallBeat && stallSeen < stallCycles) begin
            scan_ready = 1'b0;
            stallSeen++;
            if (int'(scan_data) != expData[beatCount] || int'(scan_addr) != beatCount) holdErrs++;
          end else begin
            scan_ready = 1'b1;
            beatAddr[beatCount] = int'(scan_addr);
            beatData[beatCount] = int'(scan_data);
            beatCycle[beatCount] = cyc;
            beatCount++;
          end
        end else begin
          scan_ready = 1'b1;
        end
        stepClock(1);
        cyc++;
      end
    end
    scan_ready = 1'b1;
    checkOutput("scanDoneSeen", 72'(doneSeen), 72'd1);
  endtask

  initial begin
    int cnt, errs;
    rst = 1'b1; din = '0; op = '0; waddr = '0; raddr = '0;
    scan_start = 1'b0; scan_bank = '0; scan_len = '0; scan_ready = 1'b1;
    for (int i = 0; i < 32; i++) expData[i] = 0;
    stepClock(2);
    rst = 1'b0;

    checkOutput("resetRdata", 72'(rdata), 72'd0);
    checkOutput("resetBankBusy", 72'(bank_busy), 72'd0);
    checkOutput("resetScanBusy", 72'(scan_busy), 72'd0);
    checkOutput("resetScanValid", 72'(scan_valid), 72'd0);
    checkOutput("resetScanDone", 72'(scan_done), 72'd0);

    $display("[TB] bank0 write then three-port read");
    applyStimulus(0, OP_WRITE, 5'd0, 8'd13);
    applyStimulus(0, OP_WRITE, 5'd1, 8'd12);
    applyStimulus(0, OP_WRITE, 5'd2, 8'd12);
    setRead(1, 5'd0, 5'd1, 5'd2);
    readBank(0, 5'd0, 5'd1, 5'd2);
    checkOutput("b0p0", 72'(rd(0, 0)), 72'd13);
    checkOutput("b0p1", 72'(rd(0, 1)), 72'd12);
    checkOutput("b0p2", 72'(rd(0, 2)), 72'd12);
    checkOutput("b1p0Idle", 72'(rd(1, 0)), 72'd0);
    setRead(0, 5'd3, 5'd3, 5'd3);
    stepClock(1);
    checkOutput("b0p0Hold", 72'(rd(0, 0)), 72'd13);

    $display("[TB] cross-bank same-cycle write/read");
    setOp(0, OP_WRITE); waddr[0 +: AW] = 5'd3; din = 8'd7;
    setRead(2, 5'd3, 5'd3, 5'd3); setOp(2, OP_READ);
    stepClock(1);
    setOp(0, OP_IDLE); setOp(2, OP_IDLE);
    checkOutput("b2ReadAddr3", 72'(rd(2, 0)), 72'd0);
    readBank(0, 5'd3, 5'd1, 5'd2);
    checkOutput("b0ReadAddr3", 72'(rd(0, 0)), 72'd7);

    $display("[TB] bank1 fill and clear");
    for (int i = 0; i < 5; i++) applyStimulus(1, OP_WRITE, 5'(i), 8'(i + 1));
    readBank(1, 5'd0, 5'd1, 5'd2);
    checkOutput("b1Fill0", 72'(rd(1, 0)), 72'd1);
    checkOutput("b1Fill2", 72'(rd(1, 2)), 72'd3);
    applyStimulus(1, OP_CLEAR, 5'd0, 8'd0);
    cnt = 0;
    while (bank_busy[1] && cnt < 100) begin
      cnt++;
      setOp(1, OP_IDLE);
      if (cnt == 5) begin
        setOp(1, OP_WRITE); waddr[AW +: AW] = 5'd0; din = 8'd9;
      end
      if (cnt == 10) begin
        setRead(1, 5'd3, 5'd4, 5'd4); setOp(1, OP_READ);
      end
      stepClock(1);
    end
    setOp(1, OP_IDLE);
    checkOutput("clrBusyCycles", 72'(cnt), 72'd32);
    checkOutput("clrRdataHold", 72'(rd(1, 0)), 72'd1);
    readBank(1, 5'd0, 5'd1, 5'd2);
    checkOutput("clrAddr0", 72'(rd(1, 0)), 72'd0);
    checkOutput("clrAddr1", 72'(rd(1, 1)), 72'd0);
    checkOutput("clrAddr2", 72'(rd(1, 2)), 72'd0);
    readBank(1, 5'd3, 5'd4, 5'd0);
    checkOutput("clrAddr3", 72'(rd(1, 0)), 72'd0);
    checkOutput("clrAddr4", 72'(rd(1, 1)), 72'd0);

    $display("[TB] scan bank0 length 3");
    expData[0] = 13; expData[1] = 12; expData[2] = 12; expData[3] = 7;
    runScan(2'd0, 6'd3, -1, 0);
    checkOutput("scanBeats", 72'(beatCount), 72'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("scanAddr%0d", i), 72'(beatAddr[i]), 72'(i));
      checkOutput($sformatf("scanData%0d", i), 72'(beatData[i]), 72'(expData[i]));
    end
    checkOutput("scanSpacing1", 72'(beatCycle[1] - beatCycle[0]), 72'd2);
    checkOutput("scanSpacing2", 72'(beatCycle[2] - beatCycle[1]), 72'd2);
    checkOutput("scanDoneCycle", 72'(doneCycle), 72'd7);
    checkOutput("scanBusyWhileActive", 72'(busyErrs), 72'd0);
    stepClock(1);
    checkOutput("scanDonePulse", 72'(scan_done), 72'd0);
    checkOutput("scanBusyAfter", 72'(scan_busy), 72'd0);

    $display("[TB] scan with backpressure on beat 1");
    runScan(2'd0, 6'd3, 1, 4);
    checkOutput("stallBeats", 72'(beatCount), 72'd3);
    checkOutput("stallCycles", 72'(stallSeen), 72'd4);
    checkOutput("stallHold", 72'(holdErrs), 72'd0);
    checkOutput("stallBeat1Data", 72'(beatData[1]), 72'd12);
    checkOutput("stallBeat2Addr", 72'(beatAddr[2]), 72'd2);
    checkOutput("stallDoneCycle", 72'(doneCycle), 72'd11);
    stepClock(1);

    $display("[TB] zero-length and out-of-range scans");
    runScan(2'd0, 6'd0, -1, 0);
    checkOutput("len0DoneCycle", 72'(doneCycle), 72'd1);
    checkOutput("len0Valid", 72'(validSeen), 72'd0);
    stepClock(1);
    runScan(2'd3, 6'd3, -1, 0);
    checkOutput("badBankDoneCycle", 72'(doneCycle), 72'd1);
    checkOutput("badBankBeats", 72'(beatCount), 72'd0);
    stepClock(1);

    $display("[TB] full-length scan");
    runScan(2'd0, 6'd32, -1, 0);
    checkOutput("fullBeats", 72'(beatCount), 72'd32);
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      if (beatAddr[i] != i || beatData[i] != expData[i]) errs++;
    end
    checkOutput("fullBeatContent", 72'(errs), 72'd0);
    checkOutput("fullLastAddr", 72'(beatAddr[31]), 72'd31);
    checkOutput("fullDoneCycle", 72'(doneCycle), 72'd65);
    stepClock(1);

    $display("[TB] reset during scan and clear");
    scan_bank = 2'd0; scan_len = 6'd32; scan_start = 1'b1;
    stepClock(1);
    scan_start = 1'b0;
    applyStimulus(2, OP_CLEAR, 5'd0, 8'd0);
    stepClock(3);
    checkOutput("preResetScanData", 72'(scan_data), 72'd12);
    checkOutput("preResetBusy2", 72'(bank_busy[2]), 72'd1);
    rst = 1'b1;
    stepClock(1);
    rst = 1'b0;
    checkOutput("rstScanBusy", 72'(scan_busy), 72'd0);
    checkOutput("rstScanValid", 72'(scan_valid), 72'd0);
    checkOutput("rstScanData", 72'(scan_data), 72'd0);
    checkOutput("rstScanAddr", 72'(scan_addr), 72'd0);
    checkOutput("rstBankBusy", 72'(bank_busy), 72'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (scan_done) cnt++;
      stepClock(1);
    end
    checkOutput("rstNoDone", 72'(cnt), 72'd0);
    readBank(0, 5'd0, 5'd1, 5'd3);
    checkOutput("rstMem0", 72'(rd(0, 0)), 72'd0);
    checkOutput("rstMem1", 72'(rd(0, 1)), 72'd0);
    checkOutput("rstMem3", 72'(rd(0, 2)), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
